// File: rtl/turfio_wb_initiator_if.sv
// Classic Wishbone bus bundle between the TURFIO initiator and its targets.
// dat_o carries initiator write data and dat_i carries target read data.
interface turfio_wb_initiator_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
);
   logic                      cyc;
   logic                      stb;
   logic                      we;
   logic [ADDR_WIDTH-1:0]     adr;
   logic [DATA_WIDTH-1:0]     dat_o;
   logic [DATA_WIDTH/8-1:0]   sel;
   logic [DATA_WIDTH-1:0]     dat_i;
   logic                      ack;
   logic                      err;
   logic                      rty;

   modport master (
      output cyc, stb, we, adr, dat_o, sel,
      input  dat_i, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_o, sel,
      output dat_i, ack, err, rty
   );
endinterface

// File: rtl/turfio_wb_initiator.sv
// Single-outstanding classic Wishbone initiator: one command in, one bounded WB cycle, one response out.
//
// state   | meaning
// S_IDLE  | waiting for a command; cmd_ready high
// S_CYCLE | cyc/stb asserted, waiting for ack/err/rty or timeout
// S_GAP   | one cyc-low cycle between retry attempts
// S_RESP  | response held until consumed
module turfio_wb_initiator #(
   parameter int ADDR_WIDTH     = 11,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_RETRY      = 3
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]     cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0]   cmd_sel_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [DATA_WIDTH-1:0]     rsp_dat_o,
   output logic [1:0]                rsp_status_o,
   output logic                      busy_o,
   turfio_wb_initiator_if.master     wb
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ERR     = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_RETRY   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_CYCLE, S_GAP, S_RESP} state_t;

   state_t                    state_q, state_d;
   logic                      cyc_q, cyc_d;
   logic                      we_q, we_d;
   logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
   logic [DATA_WIDTH-1:0]     dat_q, dat_d;
   logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]     rsp_dat_q, rsp_dat_d;
   logic [1:0]                rsp_status_q, rsp_status_d;
   logic [TW-1:0]             to_cnt_q, to_cnt_d;
   logic [RW-1:0]             retry_cnt_q, retry_cnt_d;

   assign cmd_ready_o  = (state_q == S_IDLE) && !wb_rst_i;
   assign busy_o       = (state_q != S_IDLE);
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_status_q;
   assign wb.cyc       = cyc_q;
   assign wb.stb       = cyc_q;
   assign wb.we        = we_q;
   assign wb.adr       = adr_q;
   assign wb.dat_o     = dat_q;
   assign wb.sel       = sel_q;

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      to_cnt_d     = to_cnt_q;
      retry_cnt_d  = retry_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               we_d        = cmd_we_i;
               adr_d       = cmd_adr_i;
               dat_d       = cmd_dat_i;
               sel_d       = cmd_sel_i;
               retry_cnt_d = '0;
               to_cnt_d    = '0;
               cyc_d       = 1'b1;
               state_d     = S_CYCLE;
            end
         end
         S_CYCLE: begin
            if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
            // cyc drops on every termination so a target never sees a duplicate strobe
            if (wb.ack) begin
               cyc_d        = 1'b0;
               rsp_dat_d    = we_q ? '0 : wb.dat_i;
               rsp_status_d = ST_OK;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else if (wb.err) begin
               cyc_d        = 1'b0;
               rsp_dat_d    = '0;
               rsp_status_d = ST_ERR;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end else if (wb.rty) begin
               cyc_d = 1'b0;
               if (retry_cnt_q < RETRY_MAX) begin
                  retry_cnt_d = retry_cnt_q + 1'b1;
                  state_d     = S_GAP;
               end else begin
                  rsp_dat_d    = '0;
                  rsp_status_d = ST_RETRY;
                  rsp_valid_d  = 1'b1;
                  state_d      = S_RESP;
               end
            end else if (to_cnt_q == TO_LAST) begin
               cyc_d        = 1'b0;
               rsp_dat_d    = '0;
               rsp_status_d = ST_TIMEOUT;
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
            end
         end
         S_GAP: begin
            to_cnt_d = '0;
            cyc_d    = 1'b1;
            state_d  = S_CYCLE;
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= ST_OK;
         to_cnt_q     <= '0;
         retry_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         to_cnt_q     <= to_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
      end
   end

endmodule

// File: tb/tb_turfio_wb_initiator.sv
// Directed bench for turfio_wb_initiator: a default instance plus a short-timeout instance.
module tb_turfio_wb_initiator;

   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_RTY  = 2;
   localparam int M_BOTH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [10:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, busy;
   logic [31:0] rsp_dat;
   logic [1:0]  rsp_status;

   logic        b_cmd_valid, b_cmd_ready, b_cmd_we;
   logic [10:0] b_cmd_adr;
   logic [31:0] b_cmd_dat;
   logic [3:0]  b_cmd_sel;
   logic        b_rsp_valid, b_rsp_ready, b_busy;
   logic [31:0] b_rsp_dat;
   logic [1:0]  b_rsp_status;

   int n_cmp = 0;
   int n_err = 0;
   int stb_bad = 0;
   int len;
   int cnt;

   turfio_wb_initiator_if wb_a ();
   turfio_wb_initiator_if wb_b ();

   turfio_wb_initiator dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
      .rsp_status_o(rsp_status), .busy_o(busy), .wb(wb_a.master)
   );

   turfio_wb_initiator #(.TIMEOUT_CYCLES(16)) dut_to (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(b_cmd_we),
      .cmd_adr_i(b_cmd_adr), .cmd_dat_i(b_cmd_dat), .cmd_sel_i(b_cmd_sel),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_dat_o(b_rsp_dat),
      .rsp_status_o(b_rsp_status), .busy_o(b_busy), .wb(wb_b.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_a(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) step();
      check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   // Target model: terminates on the k-th strobe cycle of this attempt; returns cycles cyc was high.
   task automatic attempt(input int k, input int mode, input logic [31:0] d, output int n);
      n = 0;
      while (wb_a.cyc === 1'b1 && n < 400) begin
         n++;
         if (wb_a.stb !== wb_a.cyc) stb_bad++;
         if (n == k) begin
            wb_a.dat_i = d;
            wb_a.ack   = (mode == M_ACK) || (mode == M_BOTH);
            wb_a.err   = (mode == M_ERR) || (mode == M_BOTH);
            wb_a.rty   = (mode == M_RTY);
         end
         step();
         wb_a.ack = 1'b0; wb_a.err = 1'b0; wb_a.rty = 1'b0;
         wb_a.dat_i = 32'hFFFF_FFFF;
      end
   endtask

   task automatic consume_a();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_valid_after_consume", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_after_consume", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0; rsp_ready = 0;
      b_cmd_valid = 0; b_cmd_we = 0; b_cmd_adr = 0; b_cmd_dat = 0; b_cmd_sel = 0; b_rsp_ready = 0;
      wb_a.ack = 0; wb_a.err = 0; wb_a.rty = 0; wb_a.dat_i = 32'hFFFF_FFFF;
      wb_b.ack = 0; wb_b.err = 0; wb_b.rty = 0; wb_b.dat_i = 32'hFFFF_FFFF;
      repeat (3) step();

      // reset state
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_cyc", {31'd0, wb_a.cyc}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'd0);
      check("rst_status", {30'd0, rsp_status}, 32'd0);
      check("rst_adr", {21'd0, wb_a.adr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      step();

      // write, ack on 3rd strobe cycle; rsp_valid lands in cycle k+2 counting acceptance as cycle 1
      issue_a(1'b1, 11'h000, 32'h0001_0002, 4'hF);
      check("w_cyc", {31'd0, wb_a.cyc}, 32'd1);
      check("w_we", {31'd0, wb_a.we}, 32'd1);
      check("w_dat", wb_a.dat_o, 32'h0001_0002);
      check("w_sel", {28'd0, wb_a.sel}, 32'hF);
      check("w_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      attempt(3, M_ACK, 32'hDEAD_BEEF, len);
      check("w_strobe_len", len, 32'd3);
      check("w_rsp_valid_latency", {31'd0, rsp_valid}, 32'd1);
      check("w_status", {30'd0, rsp_status}, 32'd0);
      check("w_rsp_dat_zero", rsp_dat, 32'd0);
      consume_a();

      // read, slow ack after 200 cycles; no second strobe while the response waits
      issue_a(1'b0, 11'h040, 32'd0, 4'hF);
      check("r_adr", {21'd0, wb_a.adr}, 32'h040);
      attempt(200, M_ACK, 32'h0000_1234, len);
      check("r_strobe_len", len, 32'd200);
      check("r_rsp_dat", rsp_dat, 32'h0000_1234);
      check("r_status", {30'd0, rsp_status}, 32'd0);
      step();
      check("r_no_second_stb", {31'd0, wb_a.stb}, 32'd0);
      check("r_rsp_still_valid", {31'd0, rsp_valid}, 32'd1);
      consume_a();

      // timeout on the 16-cycle instance
      check("to_cmd_ready", {31'd0, b_cmd_ready}, 32'd1);
      b_cmd_we = 1'b0; b_cmd_adr = 11'h010; b_cmd_sel = 4'hF; b_cmd_valid = 1'b1;
      step();
      b_cmd_valid = 1'b0;
      cnt = 0;
      while (wb_b.cyc === 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
      check("to_cyc_len", cnt, 32'd16);
      check("to_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
      check("to_status", {30'd0, b_rsp_status}, 32'd2);
      check("to_rsp_dat", b_rsp_dat, 32'd0);
      b_rsp_ready = 1'b1;
      step();
      b_rsp_ready = 1'b0;
      check("to_rsp_consumed", {31'd0, b_rsp_valid}, 32'd0);

      // retry on every attempt: 4 bursts with a 1-cycle gap, then RETRY_EXHAUSTED
      issue_a(1'b0, 11'h155, 32'd0, 4'h3);
      for (int i = 0; i < 4; i++) begin
         attempt(2, M_RTY, 32'h0000_0077, len);
         check("rty_burst_len", len, 32'd2);
         if (i < 3) begin
            check("rty_gap_cyc", {31'd0, wb_a.cyc}, 32'd0);
            check("rty_gap_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
         end
      end
      check("rty_exh_valid", {31'd0, rsp_valid}, 32'd1);
      check("rty_exh_status", {30'd0, rsp_status}, 32'd3);
      check("rty_exh_dat", rsp_dat, 32'd0);
      step();
      check("rty_exh_no_5th_burst", {31'd0, wb_a.cyc}, 32'd0);
      consume_a();

      // retry twice then ack
      issue_a(1'b0, 11'h156, 32'd0, 4'hF);
      for (int i = 0; i < 2; i++) begin
         attempt(1, M_RTY, 32'd0, len);
         step();
      end
      attempt(1, M_ACK, 32'h0000_00A5, len);
      check("rty2_ack_status", {30'd0, rsp_status}, 32'd0);
      check("rty2_ack_dat", rsp_dat, 32'h0000_00A5);
      consume_a();

      // err on first cycle, response held stable while not consumed
      issue_a(1'b0, 11'h200, 32'd0, 4'hF);
      attempt(1, M_ERR, 32'h5555_5555, len);
      for (int i = 0; i < 10; i++) begin
         check("err_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("err_hold_status", {30'd0, rsp_status}, 32'd1);
         check("err_hold_dat", rsp_dat, 32'd0);
         check("err_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         step();
      end
      consume_a();

      // ack and err together resolve to OK
      issue_a(1'b0, 11'h201, 32'd0, 4'hF);
      attempt(2, M_BOTH, 32'h0BAD_CAFE, len);
      check("both_status", {30'd0, rsp_status}, 32'd0);
      check("both_dat", rsp_dat, 32'h0BAD_CAFE);
      consume_a();

      // reset mid-cycle drops the strobe and discards the response
      issue_a(1'b0, 11'h123, 32'd0, 4'hF);
      for (int i = 0; i < 5; i++) step();
      check("mid_cyc_high", {31'd0, wb_a.cyc}, 32'd1);
      rst = 1'b1;
      step();
      check("mid_rst_cyc", {31'd0, wb_a.cyc}, 32'd0);
      check("mid_rst_stb", {31'd0, wb_a.stb}, 32'd0);
      check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
         step();
      end
      issue_a(1'b0, 11'h7FF, 32'd0, 4'hF);
      check("post_rst_adr", {21'd0, wb_a.adr}, 32'h7FF);
      attempt(1, M_ACK, 32'hCAFE_F00D, len);
      check("post_rst_dat", rsp_dat, 32'hCAFE_F00D);
      check("post_rst_status", {30'd0, rsp_status}, 32'd0);
      consume_a();

      check("stb_equals_cyc", stb_bad, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
